// File: rtl/sd_spi_responder_if.sv
// SPI link between the host command engine (master) and the SD card responder (slave).
interface sd_spi_responder_if;
  logic sclk;
  logic cs_n;
  logic mosi;
  logic miso;

  modport master (output sclk, output cs_n, output mosi, input miso);
  modport slave  (input sclk, input cs_n, input mosi, output miso);
endinterface

// File: rtl/sd_spi_responder.sv
// SD-card SPI-mode responder: answers CMD0/CMD1/CMD17 and streams a 512-byte block on CMD17.
// Define SD_RESP_CRC16_EN to send a real CRC16-CCITT after the data block instead of 0x0000.
module sd_spi_responder #(
  parameter int NCR_BYTES = 1,
  parameter int NAC_BYTES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sd_spi_responder_if.slave    spi,
  output logic [40:0]          rd_addr,
  input  logic [7:0]           rd_data,
  output logic                 cmd_valid,
  output logic [5:0]           cmd_index,
  output logic [31:0]          cmd_arg,
  output logic                 card_idle
);

  typedef enum logic [2:0] {S_CMD, S_NCR, S_R1, S_NAC, S_TOKEN, S_DATA, S_CRC} state_e;

  logic        sclk_meta_q, sclk_sync_q, sclk_prev_q;
  logic        cs_meta_q, cs_sync_q, mosi_meta_q, mosi_sync_q;
  logic        sclk_rise, sclk_fall;
  state_e      state_q, state_d;
  logic [38:0] rx_sr_q, rx_sr_d;
  logic [5:0]  rx_cnt_q, rx_cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [9:0]  byte_q, byte_d;
  logic [7:0]  tx_sr_q, tx_sr_d;
  logic        miso_q, miso_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [5:0]  cmd_index_q, cmd_index_d;
  logic [31:0] cmd_arg_q, cmd_arg_d;
  logic [40:0] rd_addr_q, rd_addr_d;
  logic        card_idle_q, card_idle_d;
  logic [7:0]  r1_byte, tx_byte;
`ifdef SD_RESP_CRC16_EN
  logic [15:0] crc_q, crc_d;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic din);
    logic fb;
    fb = crc[15] ^ din;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction
`endif

  // Two-stage synchronisers plus an edge register for the asynchronous SPI inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_meta_q <= 1'b0; sclk_sync_q <= 1'b0; sclk_prev_q <= 1'b0;
      cs_meta_q   <= 1'b1; cs_sync_q   <= 1'b1;
      mosi_meta_q <= 1'b1; mosi_sync_q <= 1'b1;
    end else begin
      sclk_meta_q <= spi.sclk; sclk_sync_q <= sclk_meta_q; sclk_prev_q <= sclk_sync_q;
      cs_meta_q   <= spi.cs_n; cs_sync_q   <= cs_meta_q;
      mosi_meta_q <= spi.mosi; mosi_sync_q <= mosi_meta_q;
    end
  end

  assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
  assign sclk_fall = ~sclk_sync_q & sclk_prev_q;

  // Byte to put on the wire for the current transmit state
  always_comb begin
    r1_byte = 8'h00;
    tx_byte = 8'hFF;
    case (cmd_index_q)
      6'd0:    r1_byte = 8'h01;
      6'd1:    r1_byte = 8'h00;
      6'd17:   r1_byte = card_idle_q ? 8'h05 : 8'h00;
      default: r1_byte = {5'b00000, 1'b1, 1'b0, card_idle_q};
    endcase
    case (state_q)
      S_R1:    tx_byte = r1_byte;
      S_TOKEN: tx_byte = 8'hFE;
      S_DATA:  tx_byte = rd_data;
`ifdef SD_RESP_CRC16_EN
      S_CRC:   tx_byte = byte_q[0] ? crc_q[7:0] : crc_q[15:8];
`else
      S_CRC:   tx_byte = 8'h00;
`endif
      default: tx_byte = 8'hFF;
    endcase
  end

  // Next-state logic: frame capture in S_CMD, bit-serial transmit elsewhere
  always_comb begin
    state_d     = state_q;
    rx_sr_d     = rx_sr_q;
    rx_cnt_d    = rx_cnt_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    tx_sr_d     = tx_sr_q;
    miso_d      = miso_q;
    cmd_valid_d = 1'b0;
    cmd_index_d = cmd_index_q;
    cmd_arg_d   = cmd_arg_q;
    rd_addr_d   = rd_addr_q;
    card_idle_d = card_idle_q;
`ifdef SD_RESP_CRC16_EN
    crc_d       = crc_q;
`endif
    if (cs_sync_q) begin
      state_d  = S_CMD;
      rx_cnt_d = 6'd0;
      bit_d    = 3'd0;
      byte_d   = 10'd0;
      miso_d   = 1'b1;
    end else if (state_q == S_CMD) begin
      miso_d = sclk_fall ? 1'b1 : miso_q;
      if (sclk_rise) begin
        // Only bits 46..8 are kept; the start bit is implied and CRC7 is ignored
        if (rx_cnt_q == 6'd0) begin
          rx_cnt_d = mosi_sync_q ? 6'd0 : 6'd1;
          rx_sr_d  = '0;
        end else if (rx_cnt_q == 6'd47) begin
          rx_cnt_d = 6'd0;
          if (rx_sr_q[38] && mosi_sync_q) begin
            cmd_index_d = rx_sr_q[37:32];
            cmd_arg_d   = rx_sr_q[31:0];
            cmd_valid_d = 1'b1;
            rd_addr_d   = {rx_sr_q[31:0], 9'd0};
            state_d     = S_NCR;
            bit_d       = 3'd0;
            byte_d      = 10'd0;
`ifdef SD_RESP_CRC16_EN
            crc_d       = 16'h0000;
`endif
          end else begin
            state_d = S_CMD;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 6'd1;
          rx_sr_d  = (rx_cnt_q <= 6'd39) ? {rx_sr_q[37:0], mosi_sync_q} : rx_sr_q;
        end
      end else begin
        rx_cnt_d = rx_cnt_q;
      end
    end else if (sclk_fall) begin
      // The byte is latched at its MSB so rd_addr may move on mid-byte
      if (bit_q == 3'd0) begin
        miso_d  = tx_byte[7];
        tx_sr_d = {tx_byte[6:0], 1'b0};
      end else begin
        miso_d  = tx_sr_q[7];
        tx_sr_d = {tx_sr_q[6:0], 1'b0};
      end
      bit_d = bit_q + 3'd1;
      if (state_q == S_R1 && bit_q == 3'd0) begin
        if (cmd_index_q == 6'd0) begin
          card_idle_d = 1'b1;
        end else if (cmd_index_q == 6'd1) begin
          card_idle_d = 1'b0;
        end else begin
          card_idle_d = card_idle_q;
        end
      end else begin
        card_idle_d = card_idle_q;
      end
      if (state_q == S_DATA) begin
`ifdef SD_RESP_CRC16_EN
        crc_d = crc16_step(crc_q, miso_d);
`endif
        rd_addr_d[8:0] = (bit_q == 3'd3) ? (byte_q[8:0] + 9'd1) : rd_addr_q[8:0];
      end else begin
        rd_addr_d = rd_addr_q;
      end
      if (bit_q == 3'd7) begin
        byte_d = byte_q + 10'd1;
        case (state_q)
          S_NCR: begin
            if (byte_q == 10'(NCR_BYTES - 1)) begin
              state_d = S_R1;
              byte_d  = 10'd0;
            end else begin
              state_d = S_NCR;
            end
          end
          S_R1: begin
            state_d = (cmd_index_q == 6'd17 && r1_byte == 8'h00) ? S_NAC : S_CMD;
            byte_d  = 10'd0;
          end
          S_NAC: begin
            if (byte_q == 10'(NAC_BYTES - 1)) begin
              state_d = S_TOKEN;
              byte_d  = 10'd0;
            end else begin
              state_d = S_NAC;
            end
          end
          S_TOKEN: begin
            state_d = S_DATA;
            byte_d  = 10'd0;
          end
          S_DATA: begin
            if (byte_q == 10'd511) begin
              state_d = S_CRC;
              byte_d  = 10'd0;
            end else begin
              state_d = S_DATA;
            end
          end
          S_CRC: begin
            if (byte_q == 10'd1) begin
              state_d = S_CMD;
              byte_d  = 10'd0;
            end else begin
              state_d = S_CRC;
            end
          end
          default: begin
            state_d = S_CMD;
            byte_d  = 10'd0;
          end
        endcase
      end else begin
        byte_d = byte_q;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CMD;
      rx_sr_q     <= '0;
      rx_cnt_q    <= 6'd0;
      bit_q       <= 3'd0;
      byte_q      <= 10'd0;
      tx_sr_q     <= 8'hFF;
      miso_q      <= 1'b1;
      cmd_valid_q <= 1'b0;
      cmd_index_q <= 6'd0;
      cmd_arg_q   <= 32'd0;
      rd_addr_q   <= 41'd0;
      card_idle_q <= 1'b1;
`ifdef SD_RESP_CRC16_EN
      crc_q       <= 16'h0000;
`endif
    end else begin
      state_q     <= state_d;
      rx_sr_q     <= rx_sr_d;
      rx_cnt_q    <= rx_cnt_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      tx_sr_q     <= tx_sr_d;
      miso_q      <= miso_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_index_q <= cmd_index_d;
      cmd_arg_q   <= cmd_arg_d;
      rd_addr_q   <= rd_addr_d;
      card_idle_q <= card_idle_d;
`ifdef SD_RESP_CRC16_EN
      crc_q       <= crc_d;
`endif
    end
  end

  assign spi.miso  = miso_q;
  assign rd_addr   = rd_addr_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_index = cmd_index_q;
  assign cmd_arg   = cmd_arg_q;
  assign card_idle = card_idle_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Host-side bench for sd_spi_responder: expected response bytes are queued per command
// and compared as they are clocked out of miso.
module tb_sd_spi_responder;
  localparam int HALF       = 80;  // sclk half-period: 8 clk of 10 ns
  localparam int ABORT_BYTE = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [40:0] rd_addr;
  logic [7:0]  rd_data, mem_p1;
  logic        cmd_valid;
  logic [5:0]  cmd_index;
  logic [31:0] cmd_arg;
  logic        card_idle;

  sd_spi_responder_if spi ();

  sd_spi_responder #(.NCR_BYTES(1), .NAC_BYTES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi       (spi),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .cmd_valid (cmd_valid),
    .cmd_index (cmd_index),
    .cmd_arg   (cmd_arg),
    .card_idle (card_idle)
  );

  always #5 clk = ~clk;

  // memory returns offset[7:0], two clocks after the address
  always @(posedge clk) begin
    mem_p1  <= rd_addr[7:0];
    rd_data <= mem_p1;
  end

  int          n_checks = 0;
  int          n_pass   = 0;
  int          vcount   = 0;
  logic [5:0]  v_idx    = 6'd63;
  logic [31:0] v_arg    = 32'hFFFF_FFFF;
  logic [7:0]  exp_q[$];
  logic [7:0]  rx;

  always @(negedge clk) begin
    if (cmd_valid) begin
      vcount = vcount + 1;
      v_idx  = cmd_index;
      v_arg  = cmd_arg;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  task automatic xfer(input logic [7:0] tx, output logic [7:0] rxb);
    for (int i = 7; i >= 0; i--) begin
      spi.mosi = tx[i];
      #(HALF);
      spi.sclk = 1'b1;
      rxb[i]   = spi.miso;
      #(HALF);
      spi.sclk = 1'b0;
    end
  endtask

  task automatic send6(input logic [47:0] frame);
    logic [7:0] dummy;
    for (int b = 5; b >= 0; b--) xfer(frame[b*8 +: 8], dummy);
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
    send6({2'b01, idx, arg, crc});
  endtask

  task automatic drain(input string tag, input int n);
    logic [7:0] got;
    for (int i = 0; i < n; i++) begin
      xfer(8'hFF, got);
      if (exp_q.size() == 0) check("sb_underflow", 64'(got), 64'hFFFF);
      else check(tag, 64'(got), 64'(exp_q.pop_front()));
    end
  endtask

  function automatic logic [15:0] crc16_ref(input int n);
    logic [15:0] c;
    c = 16'h0000;
    for (int k = 0; k < n; k++) begin
      c = c ^ {8'(k), 8'h00};
      for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  initial begin
    logic [15:0] crc_exp;
    rst_n    = 1'b0;
    spi.cs_n = 1'b1;
    spi.sclk = 1'b0;
    spi.mosi = 1'b1;
    #23;
    check("rst_miso", 64'(spi.miso), 64'd1);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_cmd_index", 64'(cmd_index), 64'd0);
    check("rst_cmd_arg", 64'(cmd_arg), 64'd0);
    check("rst_rd_addr", 64'(rd_addr), 64'd0);
    check("rst_card_idle", 64'(card_idle), 64'd1);
    #30 rst_n = 1'b1;
    #50 spi.cs_n = 1'b0;
    #40;

    // CMD0: NCR 0xFF then R1 0x01
    send_cmd(6'd0, 32'd0, 8'h95);
    check("cmd0_valid_cnt", 64'(vcount), 64'd1);
    check("cmd0_index", 64'(v_idx), 64'd0);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
    drain("cmd0_resp", 2);
    check("cmd0_idle", 64'(card_idle), 64'd1);

    // CMD17 while idle: R1 0x05 and no token afterwards
    send_cmd(6'd17, 32'd0, 8'h01);
    check("cmd17i_index", 64'(v_idx), 64'd17);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h05); exp_q.push_back(8'hFF);
    drain("cmd17i_resp", 3);

    // malformed frames: end bit 0, then transmission bit 0
    send6(48'h40_00_00_00_00_94);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    drain("bad_end_bit", 2);
    send6(48'h00_00_00_00_00_95);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
    drain("bad_tx_bit", 2);
    check("bad_no_valid", 64'(vcount), 64'd2);

    send_cmd(6'd0, 32'd0, 8'h95);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
    drain("cmd0b_resp", 2);
    check("cmd0b_valid_cnt", 64'(vcount), 64'd3);

    // CMD1 leaves idle
    send_cmd(6'd1, 32'd0, 8'hF9);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    drain("cmd1_resp", 2);
    check("cmd1_idle", 64'(card_idle), 64'd0);

    // full block read of block 3
    send_cmd(6'd17, 32'd3, 8'h01);
    check("cmd17_arg", 64'(v_arg), 64'd3);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF); exp_q.push_back(8'hFE);
    drain("cmd17_hdr", 5);
    check("cmd17_rd_blk", 64'(rd_addr[40:9]), 64'd3);
    for (int k = 0; k < 512; k++) exp_q.push_back(8'(k));
`ifdef SD_RESP_CRC16_EN
    crc_exp = crc16_ref(512);
`else
    crc_exp = 16'h0000;
`endif
    exp_q.push_back(crc_exp[15:8]); exp_q.push_back(crc_exp[7:0]);
    exp_q.push_back(8'hFF);
    drain("cmd17_data", 515);
    check("cmd17_rd_end", 64'(rd_addr), 64'({32'd3, 9'd0}));

    // unknown CMD8 while not idle: illegal-command bit only
    send_cmd(6'd8, 32'h0000_01AA, 8'h87);
    check("cmd8_index", 64'(v_idx), 64'd8);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h04);
    drain("cmd8_resp", 2);

    // abort a block read with cs_n partway through the data
    send_cmd(6'd17, 32'd5, 8'h01);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF); exp_q.push_back(8'hFF); exp_q.push_back(8'hFE);
    for (int k = 0; k < ABORT_BYTE; k++) exp_q.push_back(8'(k));
    drain("abort_pre", 5 + ABORT_BYTE);
    spi.cs_n = 1'b1;
    #100;
    check("abort_miso", 64'(spi.miso), 64'd1);
    xfer(8'hFF, rx);
    check("abort_cs_hi_byte", 64'(rx), 64'hFF);
    check("abort_idle_kept", 64'(card_idle), 64'd0);
    spi.cs_n = 1'b0;
    #40;
    send_cmd(6'd0, 32'd0, 8'h95);
    exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
    drain("abort_cmd0", 2);
    check("abort_cmd0_idle", 64'(card_idle), 64'd1);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
